pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central stall/flush controller for the five-stage 16-bit pipeline.
- Sequences the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers by driving their enables and bubble (flush) controls.
- Resolves load-use hazards, taken-branch redirects, instruction/data memory stalls and halt draining.
- Also keeps a saturating stall-cycle counter.

Parameters:
- CNT_W, 16, width of the stall_cycles performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_rs, id_rt  in  3 each  source register numbers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt
- id_halt  in  1  ID stage holds a HALT instruction
- ex_memRead  in  1  instruction in EX is a load
- ex_regSel  in  3  destination register of the instruction in EX
- mem_branch  in  1  branch/jump taken, resolved in MEM (EX/MEM branch output)
- wb_halt  in  1  HALT has reached WB (MEM/WB halt output)
- imem_stall  in  1  instruction memory has not returned a valid word this cycle
- dmem_stall  in  1  data memory access in MEM is still busy
- pc_en  out  1  PC register enable
- pc_sel  out  1  1 = PC loads the branch target, 0 = PC loads PC+2
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a NOP bubble (all control bits 0) on this edge
- halted  out  1  processor halted
- stall_cycles  out  CNT_W  count of cycles in which pc_en=0 while not HALTED

Behaviour:
- Outputs are combinational from the current state and inputs. The state register and counter update on posedge clk.
- States: RUN, DRAIN, HALTED.
- Reset (rst=1 at edge): state=RUN, stall_cycles=0.
  - While rst is asserted, all enables are 1, all flushes are 0, pc_sel=0 and halted=0.
  - Reset asserted mid-stall or in HALTED returns to RUN on the next edge.
- Priority per cycle, highest first:
  1. HALTED:
     - All enables 0, all flushes 0, halted=1.
     - Stays in HALTED until rst.
  2. wb_halt=1 (RUN or DRAIN):
     - Next state HALTED.
     - This cycle: pc_en=0, all other enables 1, memwb_flush=0.
  3. dmem_stall=1:
     - pc_en, ifid_en, idex_en and exmem_en are 0.
     - memwb_en=1 and memwb_flush=1, so WB sees a bubble and never double-writes.
     - mem_branch is held in the frozen EX/MEM register and is acted on once dmem_stall drops.
  4. mem_branch=1:
     - pc_en=1, pc_sel=1.
     - ifid_flush, idex_flush and exmem_flush all 1; all enables 1.
     - A DRAIN state returns to RUN, because the HALT was on the wrong path.
     - Overrides load-use and imem_stall.
  5. Load-use hazard:
     - Condition: ex_memRead && ((id_uses_rs && id_rs==ex_regSel) || (id_uses_rt && id_rt==ex_regSel)).
     - pc_en=0, ifid_en=0, idex_flush=1, other enables 1.
     - imem_stall is ignored this cycle, since the fetch is retried.
  6. imem_stall=1, or state is DRAIN:
     - pc_en=0, ifid_flush=1, downstream enables 1.
  7. Otherwise: all enables 1, all flushes 0, pc_sel=0.
- DRAIN entry:
  - In RUN, when id_halt=1 and no rule 1–5 applies, that cycle is normal (HALT advances to EX) and the next state is DRAIN.
  - DRAIN fetches nothing new and inserts IF/ID bubbles until wb_halt (go to HALTED) or mem_branch (go to RUN).
- Counter: stall_cycles increments by 1 in every non-HALTED, non-reset cycle with pc_en=0. It saturates at all-ones and never wraps.
- A flush with its enable at 0 never occurs. Where flush=1, the matching enable is 1.

Test Plan:
- Reset, then 5 clean cycles: all enables 1, flushes 0, stall_cycles=0, halted=0.
- Load-use: ex_memRead=1, ex_regSel=3, id_rs=3, id_uses_rs=1 for 1 cycle → pc_en=0, ifid_en=0, idex_flush=1, stall_cycles=1. Same case with id_uses_rs=0 → no stall.
- dmem_stall high 3 cycles with mem_branch=1 → 3 cycles of freeze with memwb_flush=1; on the 4th cycle pc_sel=1 and 3 flushes asserted; stall_cycles=3.
- mem_branch=1 together with the load-use condition and imem_stall=1 → branch wins: pc_en=1, pc_sel=1, ifid/idex/exmem_flush=1.
- id_halt=1, then 3 cycles later wb_halt=1 → DRAIN with ifid_flush=1 for those cycles, then halted=1 and all enables 0; rst=1 returns to RUN.
- id_halt=1, then mem_branch=1 during DRAIN → back to RUN, no halt. Separately, force 2^16 stall cycles → stall_cycles holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and pipeline-register controls exchanged between the
// stall/flush controller (master) and the five-stage datapath (slave).
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [2:0]       id_rs;
  logic [2:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_halt;
  logic             ex_memRead;
  logic [2:0]       ex_regSel;
  logic             mem_branch;
  logic             wb_halt;
  logic             imem_stall;
  logic             dmem_stall;

  logic             pc_en;
  logic             pc_sel;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt,
    input  ex_memRead, ex_regSel, mem_branch, wb_halt,
    input  imem_stall, dmem_stall,
    output pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, memwb_flush,
    output halted, stall_cycles
  );

  modport slave (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt,
    output ex_memRead, ex_regSel, mem_branch, wb_halt,
    output imem_stall, dmem_stall,
    input  pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
    input  halted, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the five-stage pipeline: resolves hazards,
// branch redirects, memory stalls and halt draining; counts stall cycles.
module pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e           state_r;
  state_e           nextState_s;
  logic [CNT_W-1:0] stallCnt_r;

  logic loadUse_s;
  logic fetchBubble_s;
  logic countEn_s;
  logic pcEn_s, pcSel_s, ifidEn_s, idexEn_s, exmemEn_s, memwbEn_s;
  logic ifidFlush_s, idexFlush_s, exmemFlush_s, memwbFlush_s, halted_s;

  // Hazard detection and per-cycle control decode in priority order.
  always_comb begin
    loadUse_s     = bus.ex_memRead &&
                    ((bus.id_uses_rs && (bus.id_rs == bus.ex_regSel)) ||
                     (bus.id_uses_rt && (bus.id_rt == bus.ex_regSel)));
    fetchBubble_s = bus.imem_stall || (state_r == DRAIN);
    nextState_s   = state_r;
    pcEn_s        = 1'b1;
    pcSel_s       = 1'b0;
    ifidEn_s      = 1'b1;
    idexEn_s      = 1'b1;
    exmemEn_s     = 1'b1;
    memwbEn_s     = 1'b1;
    ifidFlush_s   = 1'b0;
    idexFlush_s   = 1'b0;
    exmemFlush_s  = 1'b0;
    memwbFlush_s  = 1'b0;
    halted_s      = 1'b0;

    if (rst) begin
      nextState_s = RUN;
    end else if (state_r == HALTED) begin
      pcEn_s    = 1'b0;
      ifidEn_s  = 1'b0;
      idexEn_s  = 1'b0;
      exmemEn_s = 1'b0;
      memwbEn_s = 1'b0;
      halted_s  = 1'b1;
    end else if (bus.wb_halt) begin
      pcEn_s      = 1'b0;
      nextState_s = HALTED;
    end else if (bus.dmem_stall) begin
      // Freeze everything up to MEM; WB takes a bubble so nothing retires twice.
      pcEn_s       = 1'b0;
      ifidEn_s     = 1'b0;
      idexEn_s     = 1'b0;
      exmemEn_s    = 1'b0;
      memwbFlush_s = 1'b1;
    end else if (bus.mem_branch) begin
      pcSel_s      = 1'b1;
      ifidFlush_s  = 1'b1;
      idexFlush_s  = 1'b1;
      exmemFlush_s = 1'b1;
      nextState_s  = RUN;
    end else if (loadUse_s) begin
      pcEn_s      = 1'b0;
      ifidEn_s    = 1'b0;
      idexFlush_s = 1'b1;
    end else begin
      pcEn_s      = !fetchBubble_s;
      ifidFlush_s = fetchBubble_s;
      // HALT leaves ID normally; from here on only bubbles are fetched.
      if ((state_r == RUN) && bus.id_halt) begin
        nextState_s = DRAIN;
      end else begin
        nextState_s = state_r;
      end
    end

    countEn_s = !rst && (state_r != HALTED) && !pcEn_s &&
                (stallCnt_r != {CNT_W{1'b1}});
  end

  // State register and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RUN;
      stallCnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= nextState_s;
      if (countEn_s) begin
        stallCnt_r <= stallCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.pc_en        = pcEn_s;
  assign bus.pc_sel       = pcSel_s;
  assign bus.ifid_en      = ifidEn_s;
  assign bus.idex_en      = idexEn_s;
  assign bus.exmem_en     = exmemEn_s;
  assign bus.memwb_en     = memwbEn_s;
  assign bus.ifid_flush   = ifidFlush_s;
  assign bus.idex_flush   = idexFlush_s;
  assign bus.exmem_flush  = exmemFlush_s;
  assign bus.memwb_flush  = memwbFlush_s;
  assign bus.halted       = halted_s;
  assign bus.stall_cycles = stallCnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: an action-table model checked every cycle
// plus hand-computed literal expectations for the key scenarios.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  pipe_ctrl_if #(.CNT_W(16)) bus ();
  pipe_ctrl #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Output word order: pc_en pc_sel ifid/idex/exmem/memwb_en, four flushes, halted.
  localparam logic [10:0] V_NORMAL  = 11'b1_0_1111_0000_0;
  localparam logic [10:0] V_HALTED  = 11'b0_0_0000_0000_1;
  localparam logic [10:0] V_RETIRE  = 11'b0_0_1111_0000_0;
  localparam logic [10:0] V_DFREEZE = 11'b0_0_0001_0001_0;
  localparam logic [10:0] V_REDIR   = 11'b1_1_1111_1110_0;
  localparam logic [10:0] V_LOADUSE = 11'b0_0_0111_0100_0;
  localparam logic [10:0] V_BUBBLE  = 11'b0_0_1111_1000_0;

  int mMode = 0;   // 0 running, 1 draining, 2 halted
  int mCnt  = 0;

  function automatic logic [10:0] dutVec();
    return {bus.pc_en, bus.pc_sel, bus.ifid_en, bus.idex_en, bus.exmem_en,
            bus.memwb_en, bus.ifid_flush, bus.idex_flush, bus.exmem_flush,
            bus.memwb_flush, bus.halted};
  endfunction

  function automatic bit hazard();
    bit rsHit, rtHit;
    rsHit = bus.id_uses_rs && (int'(bus.id_rs) == int'(bus.ex_regSel));
    rtHit = bus.id_uses_rt && (int'(bus.id_rt) == int'(bus.ex_regSel));
    return bus.ex_memRead && (rsHit || rtHit);
  endfunction

  function automatic logic [10:0] modelVec();
    if (rst)                               return V_NORMAL;
    if (mMode == 2)                        return V_HALTED;
    if (bus.wb_halt)                       return V_RETIRE;
    if (bus.dmem_stall)                    return V_DFREEZE;
    if (bus.mem_branch)                    return V_REDIR;
    if (hazard())                          return V_LOADUSE;
    if (bus.imem_stall || mMode == 1)      return V_BUBBLE;
    return V_NORMAL;
  endfunction

  // Every cycle: compare against the model, then advance the model to the next edge.
  always @(negedge clk) begin
    logic [10:0] expV;
    expV = modelVec();
    checks++;
    if (dutVec() !== expV) begin
      failures++;
      $display("FAIL model_outputs t=%0t actual=%b required=%b", $time, dutVec(), expV);
    end
    checks++;
    if (bus.stall_cycles !== 16'(mCnt)) begin
      failures++;
      $display("FAIL model_stall_cycles t=%0t actual=%0d required=%0d", $time, bus.stall_cycles, mCnt);
    end
    if (rst) begin
      mMode = 0;
      mCnt  = 0;
    end else begin
      if (mMode != 2 && expV[10] == 1'b0 && mCnt < 65535) mCnt = mCnt + 1;
      if (mMode == 2)                 mMode = 2;
      else if (bus.wb_halt)           mMode = 2;
      else if (bus.dmem_stall)        mMode = mMode;
      else if (bus.mem_branch)        mMode = 0;
      else if (hazard())              mMode = mMode;
      else if (mMode == 0 && bus.id_halt) mMode = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chkVec(input string name, input logic [10:0] expV);
    @(negedge clk);
    checks++;
    if (dutVec() !== expV) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, dutVec(), expV);
    end
  endtask

  task automatic chkCnt(input string name, input logic [15:0] expC);
    checks++;
    if (bus.stall_cycles !== expC) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, bus.stall_cycles, expC);
    end
  endtask

  task automatic clearIn();
    bus.id_rs = 3'd0;      bus.id_rt = 3'd0;
    bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
    bus.id_halt = 1'b0;    bus.ex_memRead = 1'b0;
    bus.ex_regSel = 3'd0;  bus.mem_branch = 1'b0;
    bus.wb_halt = 1'b0;    bus.imem_stall = 1'b0;
    bus.dmem_stall = 1'b0;
  endtask

  initial begin
    clearIn();
    rst = 1'b1;
    chkVec("reset_outputs", V_NORMAL);
    step();
    step();
    rst = 1'b0;
    chkCnt("reset_count", 16'd0);
    repeat (5) begin
      chkVec("clean_run", V_NORMAL);
      step();
    end
    chkCnt("clean_count", 16'd0);

    // Load-use on rs, then the same operands without the rs read.
    bus.ex_memRead = 1'b1; bus.ex_regSel = 3'd3; bus.id_rs = 3'd3; bus.id_uses_rs = 1'b1;
    chkVec("loaduse_rs", V_LOADUSE);
    step();
    chkCnt("loaduse_count", 16'd1);
    bus.id_uses_rs = 1'b0;
    chkVec("loaduse_no_read", V_NORMAL);
    step();
    chkCnt("no_read_count", 16'd1);
    bus.ex_regSel = 3'd5; bus.id_rt = 3'd5; bus.id_uses_rt = 1'b1;
    chkVec("loaduse_rt", V_LOADUSE);
    step();
    chkCnt("loaduse_rt_count", 16'd2);
    clearIn();

    // Data-memory stall holding a taken branch in EX/MEM.
    bus.dmem_stall = 1'b1; bus.mem_branch = 1'b1;
    repeat (3) begin
      chkVec("dmem_freeze", V_DFREEZE);
      step();
    end
    bus.dmem_stall = 1'b0;
    chkVec("branch_after_dmem", V_REDIR);
    step();
    chkCnt("dmem_count", 16'd5);

    // Branch outranks load-use and instruction-memory stall.
    bus.ex_memRead = 1'b1; bus.ex_regSel = 3'd2; bus.id_rs = 3'd2; bus.id_uses_rs = 1'b1;
    bus.imem_stall = 1'b1;
    chkVec("branch_wins", V_REDIR);
    step();
    chkCnt("branch_wins_count", 16'd5);
    clearIn();

    // HALT drains then retires.
    bus.id_halt = 1'b1;
    chkVec("halt_in_id", V_NORMAL);
    step();
    bus.id_halt = 1'b0;
    repeat (2) begin
      chkVec("drain_bubble", V_BUBBLE);
      step();
    end
    bus.wb_halt = 1'b1;
    chkVec("halt_retire", V_RETIRE);
    step();
    bus.wb_halt = 1'b0;
    chkCnt("drain_count", 16'd8);
    bus.imem_stall = 1'b1;
    repeat (3) begin
      chkVec("halted", V_HALTED);
      step();
    end
    chkCnt("halted_count", 16'd8);
    bus.imem_stall = 1'b0;
    rst = 1'b1;
    chkVec("reset_from_halted", V_NORMAL);
    step();
    rst = 1'b0;
    chkVec("run_after_reset", V_NORMAL);
    chkCnt("count_after_reset", 16'd0);

    // Wrong-path HALT cancelled by a branch during drain.
    bus.id_halt = 1'b1;
    step();
    bus.id_halt = 1'b0;
    chkVec("drain_before_branch", V_BUBBLE);
    step();
    bus.mem_branch = 1'b1;
    chkVec("drain_branch", V_REDIR);
    step();
    bus.mem_branch = 1'b0;
    chkVec("run_after_cancel", V_NORMAL);
    step();
    chkCnt("cancel_count", 16'd1);

    // Counter saturation.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.imem_stall = 1'b1;
    repeat (65534) step();
    chkCnt("count_fffe", 16'hFFFE);
    step();
    chkCnt("count_ffff", 16'hFFFF);
    repeat (5) step();
    chkCnt("count_saturated", 16'hFFFF);
    clearIn();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
